// File: rtl/prg_cache.sv
// prg_cache: direct-mapped read-only program cache for the NeonFox fetch port.
// A lookup answers one cycle after the address edge. A miss bursts a full line
// from program memory over mem_ren/mem_ready, then replays the held address.
// Optional feature: define PRG_CACHE_FLUSH_EN to add the flush port and the
// deferred-flush logic; without it valid bits clear only on reset.
module prg_cache #(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] prg_address,
  output logic [15:0] prg_data,
  output logic        p_cache_miss,
  output logic [31:0] mem_address,
  output logic        mem_ren,
  input  logic        mem_ready,
  input  logic [15:0] mem_data
`ifdef PRG_CACHE_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned RAM_AW   = INDEX_BITS + OFFSET_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << RAM_AW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_REREAD = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_d;

  logic [31:0]            addr_q;
  logic                   addr_valid_q;
  logic [TAG_BITS-1:0]    tag_q;
  logic                   valid_q;
  logic [OFFSET_BITS-1:0] cnt;
  logic [LINES-1:0]       valid_r;

  logic [TAG_BITS-1:0]    tag_arr [LINES];
  logic [15:0]            data_ram [WORDS];

  logic [RAM_AW-1:0]      rd_addr;
  logic [INDEX_BITS-1:0]  rd_idx;
  logic [INDEX_BITS-1:0]  fill_idx;
  logic [RAM_AW-1:0]      fill_addr;
  logic                   hit;
  logic                   miss_idle;
  logic                   fill_beat;
  logic                   fill_last;

`ifdef PRG_CACHE_FLUSH_EN
  logic flush_pending;
  logic flush_apply;

  // A flush takes effect only on an IDLE edge; earlier requests wait there.
  always_comb begin
    flush_apply = (state == S_IDLE) & (flush | flush_pending);
  end

  // Remember a flush that arrives while a line is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pending <= 1'b0;
    end else if (state == S_IDLE) begin
      flush_pending <= 1'b0;
    end else if (flush) begin
      flush_pending <= 1'b1;
    end
  end
`endif

  // Lookup, miss detection and next-state decode.
  always_comb begin
    rd_addr      = addr_q[RAM_AW-1:0];
    state_d      = state;
    if (state == S_IDLE) begin
      rd_addr = prg_address[RAM_AW-1:0];
    end
    rd_idx       = rd_addr[RAM_AW-1:OFFSET_BITS];
    fill_idx     = addr_q[OFFSET_BITS +: INDEX_BITS];
    fill_addr    = {fill_idx, cnt};
    hit          = addr_valid_q & valid_q & (tag_q == addr_q[31 -: TAG_BITS]);
    miss_idle    = (state == S_IDLE) & addr_valid_q & ~hit;
    fill_beat    = (state == S_FILL) & mem_ready;
    fill_last    = fill_beat & (&cnt);
    p_cache_miss = (state != S_IDLE) | miss_idle;
    case (state)
      S_IDLE:   if (miss_idle) state_d = S_FILL;
      S_FILL:   if (fill_last) state_d = S_REREAD;
      S_REREAD: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Address capture, beat counter and fill request generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= 32'd0;
      addr_valid_q <= 1'b0;
      cnt          <= '0;
      mem_ren      <= 1'b0;
      mem_address  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_valid_q <= 1'b1;
          if (miss_idle) begin
            cnt         <= '0;
            mem_ren     <= 1'b1;
            mem_address <= {addr_q[31:OFFSET_BITS], OFFSET_BITS'(0)};
          end else begin
            addr_q <= prg_address;
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            cnt <= cnt + OFFSET_BITS'(1);
            if (&cnt) begin
              mem_ren <= 1'b0;
            end else begin
              mem_address <= {addr_q[31:OFFSET_BITS], cnt + OFFSET_BITS'(1)};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line valid bits: set when a fill completes, cleared by reset or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
    end else begin
`ifdef PRG_CACHE_FLUSH_EN
      if (flush_apply) begin
        valid_r <= '0;
      end
`endif
      if (fill_last) begin
        valid_r[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data array writes during fill; arrays carry no reset.
  always_ff @(posedge clk) begin
    if (fill_beat) begin
      data_ram[fill_addr] <= mem_data;
    end
    if (fill_last) begin
      tag_arr[fill_idx] <= addr_q[31 -: TAG_BITS];
    end
  end

  // Synchronous read of tag, valid and data at the lookup (or replay) address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q    <= '0;
      valid_q  <= 1'b0;
      prg_data <= 16'd0;
    end else begin
      tag_q    <= tag_arr[rd_idx];
`ifdef PRG_CACHE_FLUSH_EN
      valid_q  <= valid_r[rd_idx] & ~flush_apply;
`else
      valid_q  <= valid_r[rd_idx];
`endif
      prg_data <= data_ram[rd_addr];
    end
  end

endmodule

// File: doc/prg_cache.md
# prg_cache

Direct-mapped, read-only program cache between the NeonFox core's instruction fetch port and the external program memory controller. It answers `prg_address` with `prg_data` one cycle later. On a miss it raises `p_cache_miss`, bursts a full line in from memory over a ready/enable handshake, then replays the held address. The core freezes fetch while `p_cache_miss` is high.

## Interface
Parameters:
- `INDEX_BITS`, 6: line index width; number of lines is 2^INDEX_BITS.
- `OFFSET_BITS`, 2: word-in-line width; LINE_WORDS = 2^OFFSET_BITS 16-bit words.

Tag width is 32 − INDEX_BITS − OFFSET_BITS. Addresses are 16-bit word addresses.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `prg_address`  in  32  fetch address from the core.
- `prg_data`  out  16  instruction word for the address sampled on the previous edge.
- `p_cache_miss`  out  1  high while `prg_data` is not valid; the core holds `prg_address`.
- `mem_address`  out  32  word address of the current fill beat.
- `mem_ren`  out  1  fill read request; held high through the whole burst.
- `mem_ready`  in  1  memory returns `mem_data` for `mem_address` this cycle.
- `mem_data`  in  16  fill data.
- `flush`  in  1  invalidate all lines. Present only with PRG_CACHE_FLUSH_EN.

## Operation
Storage:
- valid[2^INDEX_BITS] flip-flops.
- tag array.
- data RAM of 2^(INDEX_BITS+OFFSET_BITS) × 16, with synchronous read.

FSM states:
- IDLE:
  - Each edge: addr_q <= `prg_address`; the tag, valid and data RAM are read at `prg_address`.
  - hit = addr_valid_q & valid_q & (tag_q == addr_q tag field).
  - Miss (addr_valid_q & ~hit): `p_cache_miss`=1 combinationally; next state is FILL; beat counter cnt <= 0; addr_q is frozen.
- FILL:
  - `mem_ren`=1; `mem_address` = {addr_q tag, addr_q index, cnt}.
  - On each cycle with `mem_ready`=1: write `mem_data` to RAM[{index,cnt}] and increment cnt.
  - If cnt = LINE_WORDS−1 with `mem_ready`=1: write the tag, set valid[index], go to REREAD.
  - With `mem_ready`=0: hold the address and cnt, keep `mem_ren` high.
- REREAD:
  - Issue a RAM read at addr_q; `p_cache_miss` stays 1; go to IDLE.
  - In the following IDLE cycle, addr_q still holds the missed address and hits.

`p_cache_miss` = (state≠IDLE) | (IDLE & addr_valid_q & ~hit).

Reset values:
- state IDLE, all valid bits 0, addr_valid_q 0, cnt 0.
- `p_cache_miss` 0, `mem_ren` 0, `mem_address` 0, `prg_data` 0.

Boundaries:
- Reset mid-FILL: abort immediately; the line stays invalid; no further `mem_ren`.
- Conflicting address (same index, different tag): overwrite the line.
- Last line (index all ones) and cnt wrap behave like any other line.
- `prg_address` changes while `p_cache_miss`=1: ignored.

## Timing
- Hit: address A sampled at edge t; `prg_data`=RAM[A] and `p_cache_miss`=0 during cycle t+1.
- Back-to-back hits sustain one word per cycle.
- Miss with `mem_ready` held high, address A sampled at edge t:
  - cycle t+1: `p_cache_miss`=1.
  - cycles t+2 .. t+1+LINE_WORDS: FILL beats.
  - next cycle: REREAD.
  - cycle after REREAD: `prg_data` valid and `p_cache_miss`=0.
  - Total miss penalty with LINE_WORDS=4: `p_cache_miss` high for cycles t+1..t+6; data is valid at t+7.
- Every cycle of `mem_ready`=0 during FILL adds one cycle to the penalty.
- Beats are always fetched in order 0..LINE_WORDS−1; there is no critical-word-first.

## Configuration
- PRG_CACHE_FLUSH_EN defined:
  - `flush` port exists.
  - `flush`=1 in IDLE clears all valid bits at the next edge. The lookup in that same cycle still completes normally.
  - `flush` during FILL or REREAD sets flush_pending. Pending flushes are applied on the first IDLE edge, after the in-flight line completes, so that line is invalidated too.
- PRG_CACHE_FLUSH_EN undefined:
  - No `flush` port and no pending logic.
  - Valid bits clear only on `reset`.

## Test plan
- Cold miss: reset, then `prg_address`=0x100 with `mem_ready`=1 and memory word = address XOR 0xA5A5. Required: `mem_ren` high 4 cycles at addresses 0x100..0x103; `p_cache_miss` high 6 cycles; `prg_data`=0xA4A5.
- Hit stream: after the fill, present 0x101, 0x102, 0x103 on consecutive cycles. Required: `p_cache_miss`=0 throughout; `prg_data`=0xA4A4, 0xA4A7, 0xA4A6 in successive cycles.
- Conflict: fetch 0x100, then 0x200 (same index, different tag), then 0x100 again. Required: three fills in total, and `prg_data` correct each time.
- Ready stalls: drive `mem_ready`=0 on alternate beats. Required: `mem_address` is held while stalled; `p_cache_miss` is high for exactly 10 cycles; data is correct.
- Reset mid-fill: assert `reset` during beat 2. Required: `mem_ren`=0 immediately; refetching the same address misses and performs a full 4-beat fill.
- Flush (with PRG_CACHE_FLUSH_EN): flush while in FILL, then refetch the same address. Required: the in-flight fill completes, then the refetch misses again.
